// File: rtl/input_loader_if.sv
// input_loader_if: user-pin, control and cipher-side signals of the input loader.
interface input_loader_if;
  logic [7:0] pin_data;
  logic       pin_strobe;
  logic       accept_en;
  logic       cipher_ready;
  logic [7:0] data_out;
  logic       data_out_pulse;
  logic       input_ack;
  logic       busy;
  modport master (
    output pin_data, pin_strobe, accept_en, cipher_ready,
    input  data_out, data_out_pulse, input_ack, busy
  );
  modport slave (
    input  pin_data, pin_strobe, accept_en, cipher_ready,
    output data_out, data_out_pulse, input_ack, busy
  );
endinterface

// File: rtl/input_loader.sv
// input_loader: synchronizes the user strobe, captures pin_data and issues it to the cipher as a one-cycle pulse.
// Optional strobe debounce filter enabled by defining INPUT_LOADER_DEBOUNCE_EN.
module input_loader #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          nrst,
  input_loader_if.slave bus
);
  localparam int unsigned SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  typedef enum logic [1:0] {IDLE, CAPTURED, ISSUE, WAIT_RELEASE} state_t;
  state_t        state_q, state_d;
  logic [SN-1:0] sync_q, sync_d, vld_q, vld_d;
  logic          prev_q, prev_d, rise_q, rise_d, armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_s, strobe_f;
  assign strobe_s = sync_q[SN-1];
`ifdef INPUT_LOADER_DEBOUNCE_EN
  localparam int unsigned DB = (DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES;
  localparam int unsigned CW = $clog2(DB);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  always_comb begin
    cnt_d  = (strobe_s == filt_q || cnt_q == CW'(DB-1)) ? '0 : cnt_q + 1'b1;
    filt_d = (strobe_s != filt_q && cnt_q == CW'(DB-1)) ? strobe_s : filt_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
  assign strobe_f = filt_q;
`else
  assign strobe_f = strobe_s;
`endif
  // Arming needs a genuine low seen after the synchronizer has refilled, so a strobe held through reset never loads.
  always_comb begin
    sync_d  = {sync_q[SN-2:0], bus.pin_strobe};
    vld_d   = {vld_q[SN-2:0], 1'b1};
    prev_d  = strobe_f;
    rise_d  = strobe_f & ~prev_q & armed_q;
    armed_d = armed_q | (vld_q[SN-1] & ~strobe_s);
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (rise_q && bus.accept_en) begin
        state_d = CAPTURED;
        data_d  = bus.pin_data;
      end
      CAPTURED:     state_d = bus.cipher_ready ? ISSUE : CAPTURED;
      ISSUE:        state_d = WAIT_RELEASE;
      WAIT_RELEASE: state_d = strobe_f ? WAIT_RELEASE : IDLE;
      default:      state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      armed_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      armed_q <= armed_d;
      data_q  <= data_d;
    end
  end
  assign bus.data_out       = data_q;
  assign bus.data_out_pulse = (state_q == ISSUE);
  assign bus.input_ack      = (state_q != IDLE);
  assign bus.busy           = (state_q != IDLE);
endmodule
